// File: rtl/pc_pkg.sv
// Shared opcode definitions for the program counter and the decoder.
// Opcodes 6 and 7 fold onto sequential fetch.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_RESTART = 3'd0,
    PC_JMP     = 3'd1,
    PC_RET     = 3'd2,
    PC_NEXT    = 3'd3,
    PC_CALL    = 3'd4,
    PC_BRZ     = 3'd5
  } pc_op_e;

  function automatic pc_op_e pc_op_decode(input logic [2:0] raw);
    pc_op_e op;
    case (raw)
      3'd0:    op = PC_RESTART;
      3'd1:    op = PC_JMP;
      3'd2:    op = PC_RET;
      3'd4:    op = PC_CALL;
      3'd5:    op = PC_BRZ;
      default: op = PC_NEXT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack: top pointer plus level counter.
// A push when full overwrites the oldest entry and keeps the level at DEPTH.
module ret_stack #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] wr_ptr_s;
  logic             full_s;
  logic             empty_s;

  assign full_s   = (level_q == LVL_FULL);
  assign empty_s  = (level_q == {LVL_W{1'b0}});
  assign wr_ptr_s = top_q + PTR_W'(1);

  // Pointer/level next state; pointer wraps because DEPTH is a power of two.
  always_comb begin
    top_d   = top_q;
    level_d = level_q;
    if (clear_i) begin
      level_d = {LVL_W{1'b0}};
    end else if (push_i) begin
      top_d = wr_ptr_s;
      if (full_s) begin
        level_d = level_q;
      end else begin
        level_d = level_q + LVL_W'(1);
      end
    end else if (pop_i && !empty_s) begin
      top_d   = top_q - PTR_W'(1);
      level_d = level_q - LVL_W'(1);
    end else begin
      top_d   = top_q;
      level_d = level_q;
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q   <= {PTR_W{1'b0}};
      level_q <= {LVL_W{1'b0}};
    end else begin
      top_q   <= top_d;
      level_q <= level_d;
    end
  end

  // Entry storage; cleared on reset so the outputs are never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_i && !clear_i) begin
      mem_q[wr_ptr_s] <= data_i;
    end
  end

  assign data_o  = mem_q[top_q];
  assign level_o = level_q;
  assign full_o  = full_s;
  assign empty_o = empty_s;

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with built-in return-address stack and sticky
// overflow/underflow flags; drives the instruction memory address.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int unsigned                INSTR_ADDR_SIZE = 5,
  parameter int unsigned                STACK_DEPTH     = 4,
  parameter logic [INSTR_ADDR_SIZE-1:0] RESET_ADDR      = {INSTR_ADDR_SIZE{1'b0}}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall_i,
  input  logic [2:0]                     op_code_i,
  input  logic [INSTR_ADDR_SIZE-1:0]     jmp_addr_i,
  input  logic                           cond_zero_i,
  output logic [INSTR_ADDR_SIZE-1:0]     instr_addr_o,
  output logic [$clog2(STACK_DEPTH):0]   stack_level_o,
  output logic                           stack_ovf_o,
  output logic                           stack_unf_o
);

  localparam int unsigned AW = INSTR_ADDR_SIZE;

  logic [AW-1:0] pc_q, pc_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] pc_inc_s;
  logic [AW-1:0] stk_top_s;
  logic          push_s, pop_s, clear_s;
  logic          full_s, empty_s;

  assign pc_inc_s = pc_q + AW'(1);

  ret_stack #(
    .WIDTH (AW),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .clear_i (clear_s),
    .data_i  (pc_inc_s),
    .data_o  (stk_top_s),
    .level_o (stack_level_o),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Next-address mux, stack control and sticky flag update; stall holds everything.
  always_comb begin
    pc_d    = pc_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    clear_s = 1'b0;
    if (!stall_i) begin
      case (pc_op_decode(op_code_i))
        PC_RESTART: begin
          pc_d    = RESET_ADDR;
          clear_s = 1'b1;
        end
        PC_JMP: begin
          pc_d = jmp_addr_i;
        end
        PC_RET: begin
          if (!empty_s) begin
            pc_d  = stk_top_s;
            pop_s = 1'b1;
          end else begin
            pc_d  = RESET_ADDR;
            unf_d = 1'b1;
          end
        end
        PC_CALL: begin
          pc_d   = jmp_addr_i;
          push_s = 1'b1;
          if (full_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
        end
        PC_BRZ: begin
          if (cond_zero_i) begin
            pc_d = jmp_addr_i;
          end else begin
            pc_d = pc_inc_s;
          end
        end
        PC_NEXT: begin
          pc_d = pc_inc_s;
        end
        default: begin
          pc_d = pc_inc_s;
        end
      endcase
    end else begin
      pc_d = pc_q;
    end
  end

  // PC and sticky flag registers; flags clear only on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign instr_addr_o = pc_q;
  assign stack_ovf_o  = ovf_q;
  assign stack_unf_o  = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack: directed scenarios plus random ops,
// checked against a queue-based return-stack model.
module tb_pc_call_stack;

  typedef struct packed {
    logic [4:0] pc;
    logic [2:0] lvl;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b1;
  logic [2:0] op = 3'd3;
  logic [4:0] jaddr = 5'd0;
  logic       cond = 1'b0;
  logic [4:0] instr_addr;
  logic [2:0] stack_level;
  logic       stack_ovf;
  logic       stack_unf;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t       exp_q[$];
  int         m_pc;
  logic [4:0] m_stk[$];
  logic       m_ovf;
  logic       m_unf;

  pc_call_stack #(.INSTR_ADDR_SIZE(5), .STACK_DEPTH(4), .RESET_ADDR(5'd0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .op_code_i     (op),
    .jmp_addr_i    (jaddr),
    .cond_zero_i   (cond),
    .instr_addr_o  (instr_addr),
    .stack_level_o (stack_level),
    .stack_ovf_o   (stack_ovf),
    .stack_unf_o   (stack_unf)
  );

  always #5 clk = ~clk;

  // Monitor: every registered update is compared to the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (instr_addr !== e.pc || stack_level !== e.lvl ||
          stack_ovf !== e.ovf || stack_unf !== e.unf) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got pc=%0d lvl=%0d ovf=%0b unf=%0b want pc=%0d lvl=%0d ovf=%0b unf=%0b",
                 $time, instr_addr, stack_level, stack_ovf, stack_unf,
                 e.pc, e.lvl, e.ovf, e.unf);
      end
    end
  end

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Issue one op at the negedge, advance the model, queue the expectation.
  task automatic step(input logic [2:0] o, input logic [4:0] a,
                      input logic c, input logic s);
    exp_t e;
    @(negedge clk);
    op = o; jaddr = a; cond = c; stall = s;
    if (!s) begin
      case (o)
        3'd0: begin m_pc = 0; m_stk.delete(); end
        3'd1: m_pc = int'(a);
        3'd2: begin
          if (m_stk.size() > 0) m_pc = int'(m_stk.pop_back());
          else begin m_pc = 0; m_unf = 1'b1; end
        end
        3'd4: begin
          m_stk.push_back(5'((m_pc + 1) % 32));
          if (m_stk.size() > 4) begin
            void'(m_stk.pop_front());
            m_ovf = 1'b1;
          end
          m_pc = int'(a);
        end
        3'd5: m_pc = c ? int'(a) : (m_pc + 1) % 32;
        default: m_pc = (m_pc + 1) % 32;
      endcase
    end
    e.pc  = 5'(m_pc);
    e.lvl = 3'(m_stk.size());
    e.ovf = m_ovf;
    e.unf = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name, input int pc, input int lvl,
                           input logic ovf, input logic unf);
    n_checks++;
    if (int'(instr_addr) != pc || int'(stack_level) != lvl ||
        stack_ovf !== ovf || stack_unf !== unf) begin
      n_fail++;
      $display("FAIL %s got pc=%0d lvl=%0d ovf=%0b unf=%0b want pc=%0d lvl=%0d ovf=%0b unf=%0b",
               name, instr_addr, stack_level, stack_ovf, stack_unf, pc, lvl, ovf, unf);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic mid_cycle_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    stall = 1'b1;
    #1;
    check_now("async_reset", 0, 0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int budget;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_now("power_on_reset", 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Wrap from max address back to zero
    step(3'd1, 5'd31, 1'b0, 1'b0); settle(); check_now("wrap_jmp31", 31, 0, 1'b0, 1'b0);
    step(3'd3, 5'd0, 1'b0, 1'b0);  settle(); check_now("wrap_to0", 0, 0, 1'b0, 1'b0);

    // Nested call/return
    step(3'd1, 5'd3, 1'b0, 1'b0);
    step(3'd4, 5'd10, 1'b0, 1'b0); settle(); check_now("call1", 10, 1, 1'b0, 1'b0);
    step(3'd4, 5'd20, 1'b0, 1'b0); settle(); check_now("call2", 20, 2, 1'b0, 1'b0);
    step(3'd2, 5'd0, 1'b0, 1'b0);  settle(); check_now("ret1", 11, 1, 1'b0, 1'b0);
    step(3'd2, 5'd0, 1'b0, 1'b0);  settle(); check_now("ret2", 4, 0, 1'b0, 1'b0);

    // Overflow then drain into underflow
    step(3'd1, 5'd1, 1'b0, 1'b0);
    step(3'd4, 5'd2, 1'b0, 1'b0);
    step(3'd4, 5'd3, 1'b0, 1'b0);
    step(3'd4, 5'd4, 1'b0, 1'b0);
    step(3'd4, 5'd5, 1'b0, 1'b0);  settle(); check_now("full_no_ovf", 5, 4, 1'b0, 1'b0);
    step(3'd4, 5'd9, 1'b0, 1'b0);  settle(); check_now("ovf_call", 9, 4, 1'b1, 1'b0);
    step(3'd2, 5'd0, 1'b0, 1'b0);  settle(); check_now("ovf_ret1", 6, 3, 1'b1, 1'b0);
    step(3'd2, 5'd0, 1'b0, 1'b0);  settle(); check_now("ovf_ret2", 5, 2, 1'b1, 1'b0);
    step(3'd2, 5'd0, 1'b0, 1'b0);  settle(); check_now("ovf_ret3", 4, 1, 1'b1, 1'b0);
    step(3'd2, 5'd0, 1'b0, 1'b0);  settle(); check_now("ovf_ret4", 3, 0, 1'b1, 1'b0);
    step(3'd2, 5'd0, 1'b0, 1'b0);  settle(); check_now("unf_ret5", 0, 0, 1'b1, 1'b1);

    // Conditional branch both ways
    step(3'd1, 5'd7, 1'b0, 1'b0);
    step(3'd5, 5'd12, 1'b0, 1'b0); settle(); check_now("brz_not_taken", 8, 0, 1'b1, 1'b1);
    step(3'd1, 5'd7, 1'b0, 1'b0);
    step(3'd5, 5'd12, 1'b1, 1'b0); settle(); check_now("brz_taken", 12, 0, 1'b1, 1'b1);

    // Stall overrides CALL, then RESTART keeps sticky flags
    step(3'd4, 5'd15, 1'b0, 1'b0);
    step(3'd4, 5'd25, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(3'd4, 5'd2, 1'b0, 1'b1); settle(); check_now("stall_hold", 25, 2, 1'b1, 1'b1);
    end
    step(3'd0, 5'd0, 1'b0, 1'b0);  settle(); check_now("restart", 0, 0, 1'b1, 1'b1);
    step(3'd7, 5'd0, 1'b0, 1'b0);  settle(); check_now("op7_next", 1, 0, 1'b1, 1'b1);

    mid_cycle_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(0, 7));
      if (ro == 3'd0 && $urandom_range(0, 3) != 0) ro = 3'd4;
      step(ro, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0));
      if (i == 300) mid_cycle_reset();
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
